// File: rtl/inst_page_loader.sv
// ---------------------------------------------------------------------------
// inst_page_loader
//
// Loads one page of instructions from a host into a byte-lane instruction
// memory, then restarts the CPU. A reload is requested by a rising edge on
// nxt[1] while idle; nxt[0] (program finished) parks the loader in a sticky
// halted state until reset. Each accepted instruction word is written
// little-endian as BEATS consecutive byte-lane writes starting at byte
// address DEFAULT_PC_ADDR*BEATS.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   enable        advance enable; low freezes the FSM and masks strobes
//   nxt[1:0]      CPU status: [1] reload request (edge), [0] program finished
//   load_valid    host word valid
//   load_data     host instruction word
//   load_last     marks load_data as the last word of the page
//   load_ready    loader accepts a word this cycle
//   mem_own       loader owns the memory port
//   mem_we        memory write strobe
//   mem_addr      memory byte address (0 when not writing)
//   mem_dataout   memory write data (0 when not writing)
//   cpu_start     one-cycle CPU restart pulse
//   cpu_halted    sticky program-finished flag
//   words_loaded  number of words written in the last page
// ---------------------------------------------------------------------------
module inst_page_loader #(
    parameter int MEM_DATA_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH  = 10,
    parameter int INST_WIDTH      = 16,
    parameter int PAGE_DEPTH      = 8,
    parameter int DEFAULT_PC_ADDR = 250,
    localparam int WL_WIDTH       = $clog2(PAGE_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [1:0]                nxt,
    input  logic                      load_valid,
    input  logic [INST_WIDTH-1:0]     load_data,
    input  logic                      load_last,
    output logic                      load_ready,
    output logic                      mem_own,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_dataout,
    output logic                      cpu_start,
    output logic                      cpu_halted,
    output logic [WL_WIDTH-1:0]       words_loaded
);

    localparam int BEATS  = INST_WIDTH / MEM_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [MEM_ADDR_WIDTH-1:0] BASE_BYTE = MEM_ADDR_WIDTH'(DEFAULT_PC_ADDR * BEATS);
    localparam logic [BEAT_W-1:0]         LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WL_WIDTH-1:0]       LAST_WORD = WL_WIDTH'(PAGE_DEPTH - 1);

    // Elaboration-time parameter sanity
    if ((INST_WIDTH % MEM_DATA_WIDTH) != 0 || BEATS < 1) begin : g_bad_width
        $error("INST_WIDTH must be a non-zero multiple of MEM_DATA_WIDTH");
    end
    if ((DEFAULT_PC_ADDR + PAGE_DEPTH) * BEATS > (2 ** MEM_ADDR_WIDTH)) begin : g_bad_range
        $error("page does not fit in the memory address space");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        START,
        HALTED
    } state_t;

    state_t                      state_q;
    logic                        nxt1_q;
    logic [BEAT_W-1:0]           beat_q;
    logic [WL_WIDTH-1:0]         word_idx_q;
    logic [INST_WIDTH-1:0]       shreg_q;
    logic                        last_q;
    logic [MEM_ADDR_WIDTH-1:0]   ptr_q;
    logic                        own_q;
    logic                        we_q;
    logic                        ready_q;
    logic                        start_q;
    logic                        halted_q;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q;
    logic [MEM_DATA_WIDTH-1:0]   data_q;
    logic [WL_WIDTH-1:0]         words_loaded_q;

    logic reload_rise;
    logic accept;

    assign reload_rise = nxt[1] & ~nxt1_q;
    assign accept      = load_valid & load_ready;

    // Outputs are registered for the state being entered; enable only masks
    // the strobes, so a frozen beat reappears unchanged once enable returns.
    // Page addresses are contiguous ((BASE+k)*BEATS+b), so a single running
    // byte pointer replaces the multiply. The captured word is consumed
    // low lane first through a right-shifting register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            nxt1_q         <= 1'b0;
            beat_q         <= '0;
            word_idx_q     <= '0;
            shreg_q        <= '0;
            last_q         <= 1'b0;
            ptr_q          <= '0;
            own_q          <= 1'b0;
            we_q           <= 1'b0;
            ready_q        <= 1'b0;
            start_q        <= 1'b0;
            halted_q       <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            words_loaded_q <= '0;
        end else begin
            // Edge detector tracks nxt[1] in every state, even when frozen
            nxt1_q <= nxt[1];
            if (enable) begin
                case (state_q)
                    IDLE: begin
                        if (nxt[0]) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else if (reload_rise) begin
                            state_q        <= LOAD;
                            word_idx_q     <= '0;
                            words_loaded_q <= '0;
                            ptr_q          <= BASE_BYTE;
                            own_q          <= 1'b1;
                            ready_q        <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (accept) begin
                            state_q <= WRITE;
                            shreg_q <= load_data >> MEM_DATA_WIDTH;
                            last_q  <= load_last;
                            data_q  <= load_data[MEM_DATA_WIDTH-1:0];
                            addr_q  <= ptr_q;
                            ptr_q   <= ptr_q + 1'b1;
                            beat_q  <= '0;
                            we_q    <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                    WRITE: begin
                        if (beat_q == LAST_BEAT) begin
                            words_loaded_q <= word_idx_q + 1'b1;
                            we_q           <= 1'b0;
                            addr_q         <= '0;
                            data_q         <= '0;
                            if (last_q || word_idx_q == LAST_WORD) begin
                                state_q <= START;
                                own_q   <= 1'b0;
                                start_q <= 1'b1;
                            end else begin
                                state_q    <= LOAD;
                                word_idx_q <= word_idx_q + 1'b1;
                                ready_q    <= 1'b1;
                            end
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            addr_q  <= ptr_q;
                            ptr_q   <= ptr_q + 1'b1;
                            data_q  <= shreg_q[MEM_DATA_WIDTH-1:0];
                            shreg_q <= shreg_q >> MEM_DATA_WIDTH;
                        end
                    end
                    START: begin
                        state_q <= IDLE;
                        start_q <= 1'b0;
                    end
                    HALTED: begin
                        state_q <= HALTED;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign load_ready   = ready_q & enable;
    assign mem_we       = we_q & enable;
    assign mem_addr     = mem_we ? addr_q : '0;
    assign mem_dataout  = mem_we ? data_q : '0;
    assign cpu_start    = start_q & enable;
    assign mem_own      = own_q;
    assign cpu_halted   = halted_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_inst_page_loader.sv
// ---------------------------------------------------------------------------
// tb_inst_page_loader
//
// Self-checking bench for inst_page_loader (16-bit words, 8-bit lanes,
// 4-word pages, base word address 250). Accepted words push their expected
// byte writes onto a scoreboard queue; a negedge monitor pops and compares
// every write. Page scenarios come from a vector table; reset, halt and
// mid-write reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_inst_page_loader;

    localparam int MDW   = 8;
    localparam int MAW   = 10;
    localparam int IW    = 16;
    localparam int PD    = 4;
    localparam int PC    = 250;
    localparam int BEATS = IW / MDW;
    localparam int WLW   = $clog2(PD + 1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [1:0]     nxt = 2'b00;
    logic           load_valid = 1'b0;
    logic [IW-1:0]  load_data = '0;
    logic           load_last = 1'b0;
    logic           load_ready;
    logic           mem_own;
    logic           mem_we;
    logic [MAW-1:0] mem_addr;
    logic [MDW-1:0] mem_dataout;
    logic           cpu_start;
    logic           cpu_halted;
    logic [WLW-1:0] words_loaded;

    always #5 clk = ~clk;

    inst_page_loader #(
        .MEM_DATA_WIDTH (MDW),
        .MEM_ADDR_WIDTH (MAW),
        .INST_WIDTH     (IW),
        .PAGE_DEPTH     (PD),
        .DEFAULT_PC_ADDR(PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .nxt         (nxt),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .mem_own     (mem_own),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_dataout (mem_dataout),
        .cpu_start   (cpu_start),
        .cpu_halted  (cpu_halted),
        .words_loaded(words_loaded)
    );

    typedef struct {
        int addr;
        int data;
        int cyc;     // -1: cycle not checked
    } exp_t;

    typedef struct {
        logic [63:0] words;   // word i at [16*i +: 16]
        int          n;
        int          last_idx; // -1: no load_last
        int          exp_wl;
        bit          pause;    // freeze 3 cycles after beat 0 of word 1
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t vecs[5];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = -1;
    int wr_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Write/strobe monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_start) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (mem_we) begin
                wr_cnt++;
                check("we_own", {31'd0, mem_own}, 32'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write (cycle %0d)",
                             mem_addr, mem_dataout, cyc);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", {22'd0, mem_addr}, e.addr);
                    check("wr_data", {24'd0, mem_dataout}, e.data);
                    if (e.cyc >= 0) check("wr_cycle", cyc, e.cyc);
                end
            end else begin
                check("idle_bus_zero", {14'd0, mem_addr, mem_dataout}, 32'd0);
            end
        end
    end

    // Present one word until accepted; push its expected byte writes.
    task automatic send_word(input logic [15:0] w, input bit last, input int widx,
                             input bit wild, output int acc);
        bit got;
        got = 1'b0;
        acc = -1;
        load_valid = 1'b1;
        load_data  = w;
        load_last  = last;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (load_ready) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: word 0x%0h not accepted, expected acceptance within 60 cycles", w);
        end else begin
            acc = cyc;
            for (int b = 0; b < BEATS; b++) begin
                sb.push_back('{PC * BEATS + BEATS * widx + b,
                               int'((w >> (MDW * b)) & 16'h00FF),
                               wild ? -1 : acc + 1 + b});
            end
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
    endtask

    task automatic run_page(input vec_t v);
        int  acc;
        int  s0;
        int  w0;
        bit  done;
        acc = -1;
        s0 = start_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1 nxt = 2'b10;
        for (int i = 0; i < v.n; i++) begin
            send_word(v.words[i*16 +: 16], (i == v.last_idx), i, (v.pause && i == 1), acc);
            if (v.pause && i == 1) begin
                // beat 0 of word 1 is on the bus now; freeze the 3 cycles after it
                @(posedge clk);
                #1 enable = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    @(negedge clk);
                    check("pause_we", {31'd0, mem_we}, 32'd0);
                    check("pause_ready", {31'd0, load_ready}, 32'd0);
                    @(posedge clk);
                end
                #1 enable = 1'b1;
            end
        end
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (start_cnt != s0) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_timeout: got no cpu_start, expected one within 40 cycles");
        end else begin
            check("start_cycle", start_cyc, acc + BEATS + 1);
        end
        repeat (4) @(negedge clk);
        check("start_pulses", start_cnt - s0, 32'd1);
        check("words_loaded", {29'd0, words_loaded}, v.exp_wl);
        check("write_count", wr_cnt - w0, BEATS * v.exp_wl);
        check("sb_drained", sb.size(), 32'd0);
        check("no_retrigger", {31'd0, load_ready}, 32'd0);
        check("own_released", {31'd0, mem_own}, 32'd0);
        @(posedge clk);
        #1 nxt = 2'b00;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int s0;
        int w0;

        vecs[0] = '{64'hDEF0_9ABC_5678_1234, 4, -1, 4, 1'b0};
        vecs[1] = '{64'h0000_0000_5678_1234, 2,  1, 2, 1'b0};
        vecs[2] = '{64'h0000_0000_0000_A5C3, 1,  0, 1, 1'b0};
        vecs[3] = '{64'h0000_8001_FF00_0102, 3,  2, 3, 1'b0};
        vecs[4] = '{64'hDEF0_9ABC_5678_1234, 4, -1, 4, 1'b1};

        // Reset state
        enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_load_ready", {31'd0, load_ready}, 32'd0);
        check("rst_mem_own", {31'd0, mem_own}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_bus", {14'd0, mem_addr, mem_dataout}, 32'd0);
        check("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
        check("rst_cpu_halted", {31'd0, cpu_halted}, 32'd0);
        check("rst_words_loaded", {29'd0, words_loaded}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Quiet period: nxt=00 must produce nothing
        repeat (20) @(negedge clk);
        check("quiet_starts", start_cnt, 32'd0);
        check("quiet_writes", wr_cnt, 32'd0);

        // Table-driven pages
        for (int i = 0; i < 5; i++) run_page(vecs[i]);

        // Reset asserted in the middle of the write to byte 505
        s0 = start_cnt;
        @(posedge clk);
        #1 nxt = 2'b10;
        send_word(16'h1234, 1'b0, 0, 1'b0, acc);
        send_word(16'h5678, 1'b0, 1, 1'b0, acc);
        send_word(16'h9ABC, 1'b0, 2, 1'b0, acc);
        @(negedge clk);
        @(negedge clk);
        check("mid_we", {31'd0, mem_we}, 32'd1);
        check("mid_addr", {22'd0, mem_addr}, 32'd505);
        #2 rst_n = 1'b0;
        #1;
        check("async_we", {31'd0, mem_we}, 32'd0);
        check("async_own", {31'd0, mem_own}, 32'd0);
        check("async_bus", {14'd0, mem_addr, mem_dataout}, 32'd0);
        check("async_words_loaded", {29'd0, words_loaded}, 32'd0);
        check("mid_sb_drained", sb.size(), 32'd0);
        check("mid_no_start", start_cnt - s0, 32'd0);
        nxt = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_page(vecs[1]);

        // Halt has priority and is sticky
        s0 = start_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1 nxt = 2'b11;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("halted", {31'd0, cpu_halted}, 32'd1);
        check("halted_ready", {31'd0, load_ready}, 32'd0);
        check("halted_own", {31'd0, mem_own}, 32'd0);
        @(posedge clk);
        #1 nxt = 2'b00;
        repeat (3) @(posedge clk);
        #1 nxt = 2'b10;
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        repeat (20) @(negedge clk);
        check("halted_sticky", {31'd0, cpu_halted}, 32'd1);
        check("halted_no_ready", {31'd0, load_ready}, 32'd0);
        check("halted_no_writes", wr_cnt - w0, 32'd0);
        check("halted_no_start", start_cnt - s0, 32'd0);
        load_valid = 1'b0;
        load_data  = '0;
        nxt = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        check("halt_cleared", {31'd0, cpu_halted}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_page(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
